// File: rtl/clock_ctrl_pkg.sv
// Shared types and default timing constants for the MMCM clock supervisor.
// The timer-width helper keeps the derived counter width in one place.
package clock_ctrl_pkg;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 100000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRIES   = 3;
  localparam int unsigned RETRY_W           = 2;
  localparam int unsigned RELOCK_W          = 8;

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAULT
  } clk_sup_state_t;

  // Width able to hold (largest cycle parameter - 1); never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_supervisor.sv
// Sequences the MMCM reset, waits for a stable lock with bounded retries and
// holds downstream logic in reset until the clocks are trustworthy.
module clock_supervisor
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W         = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)
) (
  input  logic                clk_in1,
  input  logic                reset,
  input  logic                locked,
  input  logic                restart_req,
  output logic                mmcm_rst,
  output logic                rst_out,
  output logic                ready,
  output logic                fault,
  output logic [RETRY_W-1:0]  retry_count,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  clk_sup_state_t     state;
  clk_sup_state_t     state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               locked_s;
  logic               inc_retry;
  logic               clr_retry;
  logic               inc_relock;

  sync_2ff u_lock_sync (
    .clk   (clk_in1),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );

  // Next-state and counter side effects; outputs are decoded from the next state.
  always_comb begin
    state_nxt  = state;
    inc_retry  = 1'b0;
    clr_retry  = 1'b0;
    inc_relock = 1'b0;
    case (state)
      S_RST: begin
        if (cnt == RST_LAST) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (locked_s) begin
          state_nxt = S_STABLE;
        end else if (cnt == TO_LAST) begin
          if (retry_count == RETRY_MAX) begin
            state_nxt = S_FAULT;
          end else begin
            state_nxt = S_RST;
            inc_retry = 1'b1;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_nxt = S_WAIT;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          clr_retry = 1'b1;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_nxt  = S_RST;
          inc_relock = 1'b1;
        end else if (restart_req) begin
          state_nxt = S_RST;
        end
      end
      S_FAULT: begin
        if (restart_req) begin
          state_nxt = S_RST;
          clr_retry = 1'b1;
        end
      end
      default: state_nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state        <= S_RST;
      cnt          <= '0;
      mmcm_rst     <= 1'b1;
      rst_out      <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
      retry_count  <= '0;
      relock_count <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      mmcm_rst <= (state_nxt == S_RST) || (state_nxt == S_FAULT);
      rst_out  <= (state_nxt != S_RUN);
      ready    <= (state_nxt == S_RUN);
      fault    <= (state_nxt == S_FAULT);
      if (clr_retry)      retry_count <= '0;
      else if (inc_retry) retry_count <= retry_count + RETRY_W'(1);
      // Runtime lock losses saturate rather than wrap.
      if (inc_relock && (relock_count != '1)) relock_count <= relock_count + RELOCK_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_supervisor.sv
// Self-checking bench for clock_supervisor: directed timing scenarios plus
// randomized lock/restart/reset traffic against a behavioural model.
module tb_clock_supervisor;

  localparam int unsigned RC = 4;
  localparam int unsigned LT = 20;
  localparam int unsigned SC = 8;
  localparam int unsigned MR = 2;

  localparam int P_RST    = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAULT  = 4;

  logic       clk_in1 = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       restart_req = 1'b0;
  logic       mmcm_rst;
  logic       rst_out;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] relock_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: phase, time spent in it, and the 2-edge view of locked.
  int m_phase;
  int m_el;
  int m_retry;
  int m_relock;
  bit m_lq[$];

  clock_supervisor #(
    .RST_CYCLES    (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .clk_in1      (clk_in1),
    .reset        (reset),
    .locked       (locked),
    .restart_req  (restart_req),
    .mmcm_rst     (mmcm_rst),
    .rst_out      (rst_out),
    .ready        (ready),
    .fault        (fault),
    .retry_count  (retry_count),
    .relock_count (relock_count)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit l, input bit rr, input bit rs);
    bit ls;
    int np;
    if (rs) begin
      m_phase  = P_RST;
      m_el     = 0;
      m_retry  = 0;
      m_relock = 0;
      m_lq     = '{1'b0, 1'b0};
      return;
    end
    ls = m_lq[0];
    void'(m_lq.pop_front());
    m_lq.push_back(l);
    np = m_phase;
    case (m_phase)
      P_RST:    if (m_el + 1 == RC) np = P_WAIT;
      P_WAIT: begin
        if (ls) np = P_STABLE;
        else if (m_el + 1 == LT) begin
          if (m_retry == MR) np = P_FAULT;
          else begin
            m_retry++;
            np = P_RST;
          end
        end
      end
      P_STABLE: begin
        if (!ls) np = P_WAIT;
        else if (m_el + 1 == SC) begin
          m_retry = 0;
          np = P_RUN;
        end
      end
      P_RUN: begin
        if (!ls) begin
          m_relock = (m_relock < 255) ? m_relock + 1 : 255;
          np = P_RST;
        end else if (rr) np = P_RST;
      end
      default: begin
        if (rr) begin
          m_retry = 0;
          np = P_RST;
        end
      end
    endcase
    m_el    = (np != m_phase) ? 0 : m_el + 1;
    m_phase = np;
  endtask

  task automatic compare_model();
    check("mmcm_rst", 32'(mmcm_rst), 32'((m_phase == P_RST) || (m_phase == P_FAULT)));
    check("rst_out", 32'(rst_out), 32'(m_phase != P_RUN));
    check("ready", 32'(ready), 32'(m_phase == P_RUN));
    check("fault", 32'(fault), 32'(m_phase == P_FAULT));
    check("retry_count", 32'(retry_count), 32'(m_retry));
    check("relock_count", 32'(relock_count), 32'(m_relock));
  endtask

  // One clock edge: drive inputs, advance the model at the edge, compare at negedge.
  task automatic tick(input bit l, input bit rr, input bit rs);
    locked      = l;
    restart_req = rr;
    reset       = rs;
    @(posedge clk_in1);
    model_step(l, rr, rs);
    @(negedge clk_in1);
    compare_model();
  endtask

  task automatic wait_ready(input string tag, input int budget, output int took);
    took = 0;
    while (ready !== 1'b1 && took < budget) begin
      tick(1'b1, 1'b0, 1'b0);
      took++;
    end
    if (ready !== 1'b1) check(tag, 32'(ready), 32'd1);
  endtask

  initial begin
    int first;
    int took;
    int seen_r1;
    int seen_r2;
    int hold;
    bit lv;

    // Reset values and nominal start: locked from cycle 10, ready at cycle 21.
    tick(1'b0, 1'b0, 1'b1);
    check("rst_mmcm", 32'(mmcm_rst), 32'd1);
    check("rst_rst_out", 32'(rst_out), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    first = -1;
    for (int n = 1; n <= 25; n++) begin
      tick(n >= 11, 1'b0, 1'b0);
      if (n == 3) check("nom_mmcm_c3", 32'(mmcm_rst), 32'd1);
      if (n == 4) check("nom_mmcm_c4", 32'(mmcm_rst), 32'd0);
      if (ready === 1'b1 && first < 0) first = n;
    end
    check("nom_ready_cycle", 32'(first), 32'd21);
    check("nom_retry", 32'(retry_count), 32'd0);

    // Runtime loss: third edge after locked falls shows reset again.
    tick(1'b0, 1'b0, 1'b0);
    check("loss_e1_ready", 32'(ready), 32'd1);
    tick(1'b1, 1'b0, 1'b0);
    check("loss_e2_ready", 32'(ready), 32'd1);
    tick(1'b1, 1'b0, 1'b0);
    check("loss_e3_rst_out", 32'(rst_out), 32'd1);
    check("loss_e3_mmcm", 32'(mmcm_rst), 32'd1);
    check("loss_e3_ready", 32'(ready), 32'd0);
    check("loss_e3_relock", 32'(relock_count), 32'd1);
    wait_ready("loss_relock_timeout", 60, took);
    check("loss_ready_back", 32'(ready), 32'd1);

    // Simultaneous lock loss and restart_req counts as a relock.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("simul_mmcm", 32'(mmcm_rst), 32'd1);
    check("simul_relock", 32'(relock_count), 32'd2);
    wait_ready("simul_relock_timeout", 60, took);

    // Never locks: three attempts then fault at cycle 72.
    tick(1'b0, 1'b0, 1'b1);
    first = -1;
    seen_r1 = 0;
    seen_r2 = 0;
    for (int n = 1; n <= 200 && first < 0; n++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (n == 24) seen_r1 = 32'(retry_count);
      if (n == 48) seen_r2 = 32'(retry_count);
      if (fault === 1'b1) first = n;
    end
    check("nolock_retry_24", 32'(seen_r1), 32'd1);
    check("nolock_retry_48", 32'(seen_r2), 32'd2);
    check("nolock_fault_cycle", 32'(first), 32'd72);
    check("nolock_fault_mmcm", 32'(mmcm_rst), 32'd1);
    for (int n = 0; n < 5; n++) tick(1'b0, 1'b0, 1'b0);
    check("fault_sticky", 32'(fault), 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    check("restart_fault", 32'(fault), 32'd0);
    check("restart_retry", 32'(retry_count), 32'd0);
    check("restart_mmcm", 32'(mmcm_rst), 32'd1);

    // Stability glitch: one-cycle dropout in S_STABLE delays ready to cycle 20.
    tick(1'b0, 1'b0, 1'b1);
    first = -1;
    for (int n = 1; n <= 30; n++) begin
      tick((n >= 5) && (n != 9), 1'b0, 1'b0);
      if (ready === 1'b1 && first < 0) first = n;
      if (n == 12) check("glitch_no_retry_mmcm", 32'(mmcm_rst), 32'd0);
    end
    check("glitch_ready_cycle", 32'(first), 32'd20);
    check("glitch_retry", 32'(retry_count), 32'd0);

    // 300 lock losses saturate relock_count.
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      wait_ready("sat_relock_timeout", 60, took);
    end
    check("sat_relock", 32'(relock_count), 32'd255);

    // Reset mid-sequence from S_STABLE with a pending retry.
    tick(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 30; n++) tick(1'b0, 1'b0, 1'b0);
    check("mid_retry_pre", 32'(retry_count), 32'd1);
    for (int n = 0; n < 5; n++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    check("mid_mmcm", 32'(mmcm_rst), 32'd1);
    check("mid_rst_out", 32'(rst_out), 32'd1);
    check("mid_ready", 32'(ready), 32'd0);
    check("mid_fault", 32'(fault), 32'd0);
    check("mid_retry", 32'(retry_count), 32'd0);
    check("mid_relock", 32'(relock_count), 32'd0);

    // Randomized traffic against the model.
    for (int round = 0; round < 4; round++) begin
      tick(1'b0, 1'b0, 1'b1);
      hold = 0;
      lv = 1'b0;
      for (int n = 0; n < 600; n++) begin
        if (hold == 0) begin
          lv   = ($urandom_range(0, 3) != 0);
          hold = lv ? $urandom_range(1, 40) : $urandom_range(1, 30);
        end
        hold--;
        tick(lv, ($urandom_range(0, 15) == 0), ($urandom_range(0, 399) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_supervisor.md
# clock_supervisor

Supervises `clock_gen` from the 100 MHz board clock. Pulses the MMCM reset, waits for lock with a timeout and bounded retries, and requires lock to be stable before releasing the downstream reset. It also detects loss of lock at runtime and re-runs the sequence. It sits between the board reset and every consumer of the pixel and serializer clocks, which derive their local resets from `rst_out`.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `mmcm_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 100000: cycles to wait for lock per attempt (1 ms).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before run.
- `MAX_RETRIES`, 3: timed-out attempts allowed before fault.
- `CNT_W`, `$clog2` of the largest of the three cycle parameters: timer width (derived).

Ports:
- `clk_in1` input 1: 100 MHz board clock.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `locked` input 1: MMCM `locked`, asynchronous to `clk_in1`.
- `restart_req` input 1: single-cycle request to re-run the sequence.
- `mmcm_rst` output 1: drives `clock_gen.reset`.
- `rst_out` output 1: active-high reset for downstream domains.
- `ready` output 1: clocks valid and stable.
- `fault` output 1: retries exhausted.
- `retry_count` output 2: timed-out attempts in the current sequence.
- `relock_count` output 8: runtime lock losses, saturating at 255.

## Operation
- `locked` passes through a 2-flop synchronizer; `locked_s` is its output. Every decision uses `locked_s` only.
- There is a single down-counter-free timer `cnt` (counts up). It clears on every state change.
- States:
  - S_RST:
    - Outputs: `mmcm_rst`=1.
    - When `cnt`==RST_CYCLES-1, go to S_WAIT.
  - S_WAIT:
    - Outputs: `mmcm_rst`=0.
    - If `locked_s`, go to S_STABLE.
    - Else, when `cnt`==LOCK_TIMEOUT-1:
      - if `retry_count`==MAX_RETRIES, go to S_FAULT;
      - otherwise increment `retry_count` and go to S_RST.
  - S_STABLE:
    - If `!locked_s`, go to S_WAIT. This is a lock glitch: the timeout restarts and there is no retry increment.
    - When `cnt`==STABLE_CYCLES-1, go to S_RUN and clear `retry_count`.
  - S_RUN:
    - Outputs: `rst_out`=0, `ready`=1.
    - If `!locked_s`, increment `relock_count` (saturating) and go to S_RST.
    - Else if `restart_req`, go to S_RST.
  - S_FAULT:
    - Outputs: `mmcm_rst`=1, `fault`=1.
    - On `restart_req`, clear `retry_count` and go to S_RST.
- `restart_req` is ignored in S_RST, S_WAIT and S_STABLE.
- In S_RUN, loss of lock and `restart_req` on the same cycle go to S_RST and count as a relock.
- Output values by state:
  - `rst_out`=1 in every state except S_RUN.
  - `mmcm_rst`=1 only in S_RST and S_FAULT.
  - `ready`=1 only in S_RUN.
  - `fault`=1 only in S_FAULT.
- All outputs are registered and change on the same edge as the state.
- On `reset`:
  - state is S_RST, `cnt`=0;
  - `mmcm_rst`=1, `rst_out`=1, `ready`=0, `fault`=0;
  - `retry_count`=0, `relock_count`=0;
  - synchronizer flops are 0.
- `reset` mid-operation aborts any state immediately at the next edge.

## Timing
- After `reset` deasserts, `mmcm_rst` stays high for exactly RST_CYCLES edges.
- Lock detect: `locked` rising reaches `locked_s` after 2 edges, and S_WAIT→S_STABLE occurs on the 3rd edge.
- Release of reset: `rst_out` falls and `ready` rises exactly STABLE_CYCLES edges after entering S_STABLE, provided there are no glitches.
- Lock loss: from `locked` falling in S_RUN, `rst_out`=1 and `mmcm_rst`=1 on the 3rd edge.
- Timeout: S_WAIT lasts at most LOCK_TIMEOUT cycles.
- Worst case to fault from reset: (MAX_RETRIES+1)·(RST_CYCLES+LOCK_TIMEOUT) cycles.

## Structure
- `clock_ctrl_pkg` holds:
  - the `clk_sup_state_t` enum (S_RST, S_WAIT, S_STABLE, S_RUN, S_FAULT);
  - default parameter constants.
- Sub-module `sync_2ff`: a generic 1-bit two-flop synchronizer with sync reset. It is reused elsewhere for CDC.
- `clock_gen` is not instantiated here; the top level wires `mmcm_rst`→`reset` and `locked`→`locked`.

## Test plan
Test parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal start: `locked`=1 at cycle 10 after reset. Required: `mmcm_rst` high cycles 0–3; `rst_out` falls and `ready`=1 at cycle 21; `retry_count`=0.
- Never locks: `locked` held 0. Required: three attempts (`retry_count` 0→1→2), then `fault`=1 with `mmcm_rst`=1 at cycle 72; `restart_req` clears `fault` and `retry_count` and restarts S_RST.
- Stability glitch: `locked` drops for 1 cycle in S_STABLE. Required: return to S_WAIT; `ready` is delayed by a full 8 stable cycles after re-lock; `retry_count` is unchanged.
- Runtime loss: `locked` falls in S_RUN. Required: on the 3rd edge `rst_out`=1, `mmcm_rst`=1, `ready`=0, `relock_count`=1; the bench then re-locks and `ready` returns.
- Simultaneous events: `restart_req` on the same cycle `locked_s` drops. Required: S_RST, `relock_count`+1. Separately, 300 lock losses leave `relock_count`=255.
- Reset mid-sequence: `reset` asserted in S_STABLE. Required: next edge gives all reset values; `relock_count` and `retry_count` read 0.
